// File: rtl/vic_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
package vic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } lowest_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Scanning downward leaves the lowest set index in idx.
    function automatic lowest_t lowest_set(input logic [31:0] v);
        lowest_t r;
        r.valid = |v;
        r.idx   = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r.idx = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module prio_enc
    import vic_pkg::*;
#(
    parameter int W  = 4,
    parameter int IW = 2
) (
    input  logic [W-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [31:0] req_ext;
    lowest_t     low;

    always_comb begin
        req_ext        = '0;
        req_ext[W-1:0] = req;
        low            = lowest_set(req_ext);
        idx            = IW'(low.idx);
        valid          = low.valid;
    end

endmodule

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: edge capture, mask, fixed priority, req/ack and in-service tracking.
// Define NESTED_INT_EN to allow a higher-priority source to preempt a running handler.
module vec_int_ctrl
    import vic_pkg::*;
#(
    parameter int               N_IRQ     = 4,
    parameter logic [31:0]      BASE_ADDR = 32'h0000_0100,
    parameter int               VEC_SHIFT = 3,
    parameter logic [N_IRQ-1:0] MASK_RST  = {N_IRQ{1'b1}},
    localparam int              ID_W      = id_width(N_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_done,
    input  logic             ie_en,
    input  logic             mask_wr,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             eret,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [31:0]      int_addr,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service,
    output logic [N_IRQ-1:0] mask
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] REQ     = ST_REQ;
    localparam logic [1:0] SERVICE = ST_SERVICE;

    logic [1:0]       state_reg, state_next;
    logic [N_IRQ-1:0] hist_reg;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] id_onehot;
    logic [N_IRQ-1:0] ack_clr;
    logic [N_IRQ-1:0] pending_next;
    logic [N_IRQ-1:0] in_service_next;
    logic [ID_W-1:0]  int_id_next;
    logic [ID_W-1:0]  win_idx;
    logic             win_valid;

    assign rise      = irq_done & ~hist_reg;
    assign eligible  = pending & mask;
    assign id_onehot = N_IRQ'(1) << int_id;

    prio_enc #(.W(N_IRQ), .IW(ID_W)) u_elig_enc (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

`ifdef NESTED_INT_EN
    logic [ID_W-1:0] svc_idx;
    logic            svc_valid;

    prio_enc #(.W(N_IRQ), .IW(ID_W)) u_svc_enc (
        .req   (in_service),
        .idx   (svc_idx),
        .valid (svc_valid)
    );
`endif

    // A fresh rise wins over the ack clear of the same source.
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
        assign pending_next[gi] = (pending[gi] & ~ack_clr[gi]) | rise[gi];
    end

    always_comb begin
        state_next      = state_reg;
        int_id_next     = int_id;
        in_service_next = in_service;
        ack_clr         = '0;
        case (state_reg)
            IDLE: begin
                if (ie_en && win_valid) begin
                    state_next  = REQ;
                    int_id_next = win_idx;
                end
            end
            REQ: begin
                if (int_ack) begin
                    ack_clr         = id_onehot;
                    in_service_next = in_service | id_onehot;
                    state_next      = SERVICE;
                end else if (!ie_en || !(|(mask & id_onehot))) begin
                    state_next = (|in_service) ? SERVICE : IDLE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    in_service_next = in_service & (in_service - N_IRQ'(1));
                    if (in_service_next == '0) state_next = IDLE;
                end
`ifdef NESTED_INT_EN
                else if (ie_en && win_valid && svc_valid && (win_idx < svc_idx)) begin
                    state_next  = REQ;
                    int_id_next = win_idx;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            hist_reg   <= '0;
            pending    <= '0;
            in_service <= '0;
            mask       <= MASK_RST;
            int_req    <= 1'b0;
            int_id     <= '0;
            int_addr   <= BASE_ADDR;
        end else begin
            state_reg  <= state_next;
            hist_reg   <= irq_done;
            pending    <= pending_next;
            in_service <= in_service_next;
            if (mask_wr) mask <= mask_wdata;
            int_req    <= (state_next == REQ);
            int_id     <= int_id_next;
            int_addr   <= BASE_ADDR + (32'(int_id_next) << VEC_SHIFT);
        end
    end

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Directed and randomized checks of vec_int_ctrl against a behavioural model (N_IRQ=4).
module tb_vec_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_done;
    logic        ie_en;
    logic        mask_wr;
    logic [3:0]  mask_wdata;
    logic        int_ack;
    logic        eret;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_addr;
    logic [3:0]  pending;
    logic [3:0]  in_service;
    logic [3:0]  mask;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: phase 0 = idle, 1 = requesting, 2 = in service.
    logic [3:0] m_hist, m_pend, m_mask, m_insvc;
    int         m_phase, m_id;

    vec_int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_done   (irq_done),
        .ie_en      (ie_en),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_addr   (int_addr),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = '0; m_pend = '0; m_mask = 4'hF; m_insvc = '0;
        m_phase = 0; m_id = 0;
    endtask

    task automatic model_step();
        logic [3:0] rise, clr, elig;
        rise = irq_done & ~m_hist;
        clr  = '0;
        elig = m_pend & m_mask;
        case (m_phase)
            0: if (ie_en && elig != 0) begin m_id = lowest(elig); m_phase = 1; end
            1: begin
                if (int_ack) begin
                    clr[m_id] = 1'b1;
                    m_insvc[m_id] = 1'b1;
                    m_phase = 2;
                end else if (!ie_en || !m_mask[m_id]) begin
                    m_phase = (m_insvc != 0) ? 2 : 0;
                end
            end
            default: begin
                if (eret) begin
                    m_insvc[lowest(m_insvc)] = 1'b0;
                    if (m_insvc == 0) m_phase = 0;
                end
`ifdef NESTED_INT_EN
                else if (ie_en && elig != 0 && lowest(elig) < lowest(m_insvc)) begin
                    m_id = lowest(elig);
                    m_phase = 1;
                end
`endif
            end
        endcase
        m_pend = (m_pend & ~clr) | rise;
        m_hist = irq_done;
        if (mask_wr) m_mask = mask_wdata;
    endtask

    task automatic check_all();
        chk("int_req", {31'd0, int_req}, {31'd0, m_phase == 1});
        chk("int_id", {30'd0, int_id}, 32'(m_id));
        chk("int_addr", int_addr, 32'h0000_0100 + 32'(m_id) * 8);
        chk("pending", {28'd0, pending}, {28'd0, m_pend});
        chk("in_service", {28'd0, in_service}, {28'd0, m_insvc});
        chk("mask", {28'd0, mask}, {28'd0, m_mask});
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int  req_count;
        logic prev_req;

        reset = 1'b0; irq_done = '0; ie_en = 1'b1; mask_wr = 1'b0;
        mask_wdata = '0; int_ack = 1'b0; eret = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_addr", int_addr, 32'h0000_0100);
        reset = 1'b1;

        // Basic single request
        irq_done = 4'b0100; cyc();
        chk("basic_pend", {28'd0, pending}, 32'h4);
        cyc();
        chk("basic_req", {31'd0, int_req}, 32'd1);
        chk("basic_addr", int_addr, 32'h0000_0110);
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        chk("basic_svc", {28'd0, in_service}, 32'h4);
        irq_done = '0; eret = 1'b1; cyc(); eret = 1'b0;
        chk("basic_eret", {28'd0, in_service}, 32'h0);

        // Priority between simultaneous rises
        irq_done = 4'b1010; cyc(); cyc();
        chk("prio_id1", {30'd0, int_id}, 32'd1);
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        eret = 1'b1; cyc(); eret = 1'b0;
        cyc();
        chk("prio_id3", {30'd0, int_id}, 32'd3);
        chk("prio_addr", int_addr, 32'h0000_0118);
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        eret = 1'b1; cyc(); eret = 1'b0;
        irq_done = '0; cyc();

        // Masking and global enable
        mask_wr = 1'b1; mask_wdata = 4'b1110; cyc(); mask_wr = 1'b0;
        irq_done = 4'b0001; cyc(); cyc();
        chk("mask_noreq", {31'd0, int_req}, 32'd0);
        mask_wr = 1'b1; mask_wdata = 4'hF; cyc(); mask_wr = 1'b0;
        cyc();
        chk("unmask_req", {31'd0, int_req}, 32'd1);
        ie_en = 1'b0; cyc();
        chk("ie_drop_req", {31'd0, int_req}, 32'd0);
        chk("ie_drop_pend", {31'd0, pending[0]}, 32'd1);
        ie_en = 1'b1; cyc();
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        eret = 1'b1; cyc(); eret = 1'b0;
        irq_done = '0; cyc();

        // Level held high raises exactly one request
        irq_done = 4'b0010; req_count = 0; prev_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            int_ack = (m_phase == 1);
            eret    = (m_phase == 2);
            cyc();
            if (int_req && !prev_req) req_count++;
            prev_req = int_req;
        end
        int_ack = 1'b0; eret = 1'b0;
        chk("hold_count", 32'(req_count), 32'd1);
        irq_done = '0; cyc();

        // Re-rise in the ack cycle keeps pending set
        irq_done = 4'b0010; cyc(); cyc();
        irq_done = '0; cyc();
        irq_done = 4'b0010; int_ack = 1'b1; cyc(); int_ack = 1'b0;
        chk("rerise_pend", {31'd0, pending[1]}, 32'd1);
        eret = 1'b1; cyc(); eret = 1'b0;
        cyc();
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        eret = 1'b1; cyc(); eret = 1'b0;
        irq_done = '0; cyc();

        // Nesting behaviour
        irq_done = 4'b0100; cyc(); cyc();
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        irq_done = 4'b0101; cyc(); cyc();
`ifdef NESTED_INT_EN
        chk("nest_req", {31'd0, int_req}, 32'd1);
        chk("nest_id", {30'd0, int_id}, 32'd0);
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        chk("nest_svc", {28'd0, in_service}, 32'h5);
        eret = 1'b1; cyc();
        chk("nest_eret1", {28'd0, in_service}, 32'h4);
        cyc(); eret = 1'b0;
        chk("nest_eret2", {28'd0, in_service}, 32'h0);
`else
        chk("nonest_req", {31'd0, int_req}, 32'd0);
        eret = 1'b1; cyc(); eret = 1'b0;
        cyc();
        chk("nonest_id", {30'd0, int_id}, 32'd0);
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        eret = 1'b1; cyc(); eret = 1'b0;
`endif
        irq_done = '0; cyc();

        // Asynchronous reset while requesting
        mask_wr = 1'b1; mask_wdata = 4'b1110; irq_done = 4'b0010; cyc();
        mask_wr = 1'b0; cyc();
        chk("pre_rst_req", {31'd0, int_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_req", {31'd0, int_req}, 32'd0);
        chk("arst_pend", {28'd0, pending}, 32'h0);
        chk("arst_mask", {28'd0, mask}, 32'hF);
        chk("arst_addr", int_addr, 32'h0000_0100);
        model_reset();
        irq_done = '0;
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) irq_done = 4'($urandom);
            ie_en      = ($urandom_range(0, 7) != 0);
            mask_wr    = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom);
            int_ack    = (m_phase == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            eret       = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
